// File: rtl/noahgaertner_loader.sv
// Boot loader that clears a nibble-wide target CPU, streams a 32-nibble image into it,
// sets its run point and clocks it for a requested number of ticks. Optional: LOADER_CHECK_EN.
module noahgaertner_loader (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] run_pc,
    input  logic [7:0] run_cycles,
    input  logic       jump_en,
    input  logic       img_valid,
    input  logic [3:0] img_nibble,
    output logic       img_ready,
    output logic [7:0] cpu_io_in,
    input  logic [7:0] cpu_io_out,
    output logic       busy,
    output logic       done,
`ifdef LOADER_CHECK_EN
    output logic       load_err,
`endif
    output logic [7:0] result
);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_SETPT0, S_IMG_WAIT, S_IMG_LO, S_IMG_HI, S_SETPT, S_RUN, S_DONE
    } state_t;

    localparam logic [1:0] CMD_SETPT = 2'd2;
    localparam logic [1:0] CMD_RUN   = 2'd3;

    state_t     state_reg, state_next;
    logic       phase_reg, phase_next;
    logic [7:0] cpu_reg, cpu_next;
    logic [4:0] count_reg;
    logic [7:0] cycles_reg;
    logic [3:0] pc_reg;
    logic       jump_reg;
    logic [7:0] result_reg;
    logic       accept_start;

    assign accept_start = (state_reg == S_IDLE) && start;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_IDLE;
            phase_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
        end
    end

    // Two-phase states use phase_reg: 0 = LO half of the tick, 1 = HI half.
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CLEAR;
                    phase_next = 1'b0;
                end
            end
            S_CLEAR: begin
                phase_next = ~phase_reg;
                if (phase_reg) state_next = S_SETPT0;
            end
            S_SETPT0: begin
                phase_next = ~phase_reg;
                if (phase_reg) state_next = S_IMG_WAIT;
            end
            S_IMG_WAIT: begin
                if (img_valid) state_next = S_IMG_LO;
            end
            S_IMG_LO: state_next = S_IMG_HI;
            S_IMG_HI: begin
                phase_next = 1'b0;
                state_next = (count_reg == 5'd31) ? S_SETPT : S_IMG_WAIT;
            end
            S_SETPT: begin
                phase_next = ~phase_reg;
                if (phase_reg) state_next = (cycles_reg == 8'd0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                phase_next = ~phase_reg;
                if (phase_reg && (cycles_reg == 8'd1)) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The pin image is computed from the upcoming state so the registered pins line up with it.
    always_comb begin
        img_ready = (state_reg == S_IMG_WAIT);
        busy      = (state_reg != S_IDLE) && (state_reg != S_DONE);
        done      = (state_reg == S_DONE);
        cpu_next  = {cpu_reg[7:1], 1'b0};
        case (state_next)
            S_CLEAR:  cpu_next = phase_next ? {cpu_reg[7:1], 1'b1} : 8'h00;
            S_SETPT0: cpu_next = phase_next ? {cpu_reg[7:1], 1'b1} : {4'h0, CMD_SETPT, 2'b10};
            S_IMG_LO: cpu_next = {img_nibble, 1'b0, count_reg[4], 2'b10};
            S_IMG_HI: cpu_next = {cpu_reg[7:1], 1'b1};
            S_SETPT:  cpu_next = phase_next ? {cpu_reg[7:1], 1'b1} : {pc_reg, CMD_SETPT, 2'b10};
            S_RUN:    cpu_next = phase_next ? {cpu_reg[7:1], 1'b1} : {jump_reg, 3'b000, CMD_RUN, 2'b10};
            default:  cpu_next = {cpu_reg[7:1], 1'b0};
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_reg    <= 8'h00;
            count_reg  <= 5'd0;
            cycles_reg <= 8'd0;
            pc_reg     <= 4'd0;
            jump_reg   <= 1'b0;
            result_reg <= 8'h00;
        end else begin
            cpu_reg <= cpu_next;
            if (accept_start) begin
                pc_reg     <= run_pc;
                cycles_reg <= run_cycles;
                jump_reg   <= jump_en;
                count_reg  <= 5'd0;
            end
            if (state_reg == S_IMG_HI) count_reg <= count_reg + 5'd1;
            if ((state_reg == S_RUN) && phase_reg) cycles_reg <= cycles_reg - 8'd1;
            if (state_reg == S_DONE) result_reg <= cpu_io_out;
        end
    end

`ifdef LOADER_CHECK_EN
    logic check_reg;
    logic load_err_reg;

    // count_reg has already advanced past the nibble, so it equals the pc the target should show.
    always_ff @(posedge clock) begin
        if (reset) begin
            check_reg    <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            check_reg <= (state_reg == S_IMG_HI);
            if (accept_start) load_err_reg <= 1'b0;
            else if (check_reg && (cpu_io_out[3:0] != count_reg[3:0])) load_err_reg <= 1'b1;
        end
    end

    assign load_err = load_err_reg;
`endif

    assign cpu_io_in = cpu_reg;
    assign result    = result_reg;

endmodule

// File: doc/noahgaertner_loader.md
NOAHGAERTNER_LOADER -- requirements
Module: noahgaertner_loader

Interface
REQ-001 SHALL have port: clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high; clears all state.
REQ-003 SHALL have port: start  in  1  sampled in IDLE; begins a clear/load/run sequence.
REQ-004 SHALL have port: run_pc  in  4  target start address; latched when start is accepted.
REQ-005 SHALL have port: run_cycles  in  8  number of run ticks; latched when start is accepted.
REQ-006 SHALL have port: jump_en  in  1  value for target data bit 3 during run; latched when start is accepted.
REQ-007 SHALL have port: img_valid  in  1  upstream image nibble valid.
REQ-008 SHALL have port: img_nibble  in  4  image nibble: 16 program nibbles, then 16 data nibbles.
REQ-009 SHALL have port: img_ready  out  1  loader accepts img_nibble this cycle.
REQ-010 SHALL have port: cpu_io_in  out  8  drives target pins: [0] target clock, [1] target enable (0 = target clear), [3:2] command (0 load-prog, 1 load-data, 2 set-run-point, 3 run), [7:4] data.
REQ-011 SHALL have port: cpu_io_out  in  8  target status {accumulator[7:4], pc[3:0]}.
REQ-012 SHALL have ports: busy  out  1  sequence in progress; done  out  1  one-cycle completion pulse; result  out  8  captured cpu_io_out.

Function
REQ-013 SHALL generate each target tick as two loader cycles: LO (bit 0 = 0, bits 7:1 updated) then HI (bit 0 = 1, bits 7:1 unchanged); cpu_io_in SHALL be registered.
REQ-014 SHALL use states IDLE, CLEAR, SETPT0, IMG_WAIT, IMG_LO, IMG_HI, SETPT, RUN, DONE.
REQ-015 SHALL, in IDLE with start=1, latch run_pc, run_cycles and jump_en, assert busy, and go to CLEAR; start SHALL be ignored in all other states.
REQ-016 CLEAR SHALL issue one tick with bits 7:1 = 0, which clears the target.
REQ-017 SETPT0 SHALL issue one tick with command 2, data 0 and enable 1, which sets target pc to 0.
REQ-018 IMG_WAIT SHALL assert img_ready with clock low; img_valid&&img_ready SHALL register the nibble and a 5-bit count.
REQ-019 Each accepted nibble SHALL then produce IMG_LO then IMG_HI with data = nibble, enable 1, command 0 for count 0-15 and command 1 for count 16-31 (target pc wraps mod 16 between the two halves).
REQ-020 img_ready SHALL be 0 outside IMG_WAIT; no image tick SHALL occur without a preceding accept.
REQ-021 After the 32nd nibble, SETPT SHALL issue one tick with command 2 and data = latched run_pc.
REQ-022 RUN SHALL issue exactly run_cycles ticks with command 3 and data = {jump_en,3'b000}; run_cycles = 0 SHALL skip RUN.
REQ-023 DONE SHALL last one cycle: result <= cpu_io_out, done = 1, busy = 0, then IDLE.
REQ-024 After completion, cpu_io_in SHALL hold bits 7:1 with bit 0 = 0, so no target edge occurs and target state is preserved.
REQ-025 With img_valid held high, done SHALL assert 103 + 2*run_cycles cycles after the cycle in which start is accepted.

Reset
REQ-026 On reset: cpu_io_in = 8'h00, img_ready = 0, busy = 0, done = 0, result = 8'h00, count = 0, state = IDLE; this takes effect on the next edge.
REQ-027 Reset mid-sequence SHALL abort without a done pulse; bit 0 SHALL go low on that edge even if the loader was in a HI phase.

Configuration
REQ-028 With macro LOADER_CHECK_EN defined, the block SHALL add port load_err (out, 1, sticky) and, in the cycle after each IMG_HI, compare cpu_io_out[3:0] with (count+1) mod 16.
REQ-029 Any such mismatch SHALL set load_err; load_err SHALL be cleared by reset or by an accepted start.
REQ-030 Without LOADER_CHECK_EN, the load_err port and the compare logic SHALL be absent; behaviour is otherwise identical.

Verification
REQ-031 Reset: assert reset for 2 cycles -> cpu_io_in = 0x00, busy = 0, done = 0, img_ready = 0, result = 0x00.
REQ-032 Full run against the team CPU model: program nibbles all 2 (ADD), data nibbles all 1, run_pc = 0, run_cycles = 5, img_valid always 1 -> done at cycle 113, result = 0x55.
REQ-033 Backpressure: img_valid toggles every cycle -> exactly 32 accepts; the first 16 carry command 0 and the next 16 command 1, and nibble order is preserved.
REQ-034 run_cycles = 0, run_pc = 9 -> no command-3 tick, done at cycle 103, result = 0x09.
REQ-035 Reset asserted during an IMG_HI phase -> next cycle cpu_io_in = 0x00, busy = 0, no done pulse; a later start restarts from CLEAR. A start pulse while busy -> ignored.
REQ-036 LOADER_CHECK_EN: target model drops load tick 7 -> load_err = 1 and stays 1 until the next start; clean target -> load_err = 0.
